// File: rtl/mips32_pkg.sv
// Shared definitions for the pipe_mips32 core: opcodes, instruction classes and operand forwarding.
// Optional multiplier is controlled by PIPE_MIPS32_MUL_EN.
package mips32_pkg;

  localparam int          MEM_DEPTH = 1024;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    NOP_T, RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT
  } instr_type_e;

  function automatic instr_type_e decode_type(input logic [5:0] op);
    instr_type_e t;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: t = RR_ALU;
`ifdef PIPE_MIPS32_MUL_EN
      OP_MUL:                                t = RR_ALU;
`else
      OP_MUL:                                t = NOP_T;
`endif
      OP_ADDI, OP_SUBI, OP_SLTI:             t = RM_ALU;
      OP_LW:                                 t = LOAD;
      OP_SW:                                 t = STORE;
      OP_BNEQZ, OP_BEQZ:                     t = BRANCH;
      OP_HLT:                                t = HALT;
      default:                               t = NOP_T;
    endcase
    return t;
  endfunction

  // Destination registers are zero for non-writing instructions, so a zero match never forwards.
  function automatic logic [31:0] fwd_operand(
    input logic [4:0]  src,
    input logic [4:0]  mem_dst,
    input logic [31:0] mem_val,
    input logic [4:0]  wb_dst,
    input logic [31:0] wb_val,
    input logic [31:0] rf_val
  );
    logic [31:0] v;
    if (src != 5'd0 && src == mem_dst) v = mem_val;
    else if (src != 5'd0 && src == wb_dst) v = wb_val;
    else v = rf_val;
    return v;
  endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational ALU for pipe_mips32; loads/stores/ADDI share the adder.
// MUL exists only when PIPE_MIPS32_MUL_EN is defined.
module mips32_alu
  import mips32_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  // Operation select
  always_comb begin
    y_o = 32'd0;
    case (op_i)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: y_o = a_i + b_i;
      OP_SUB, OP_SUBI:               y_o = a_i - b_i;
      OP_AND:                        y_o = a_i & b_i;
      OP_OR:                         y_o = a_i | b_i;
      OP_SLT, OP_SLTI:               y_o = {31'd0, ($signed(a_i) < $signed(b_i))};
`ifdef PIPE_MIPS32_MUL_EN
      OP_MUL:                        y_o = a_i * b_i;
`else
      OP_MUL:                        y_o = 32'd0;
`endif
      default:                       y_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/pipe_mips32.sv
// Five-stage MIPS32-subset core with unified word memory and MEM/WB operand forwarding.
// PIPE_MIPS32_MUL_EN enables the MUL instruction.
module pipe_mips32
  import mips32_pkg::*;
(
  input logic clk,
  input logic rst_n
);

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_DEPTH-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  logic [31:0] if_id_ir_q, if_id_npc_q;
  logic [5:0]  id_ex_op_q;
  logic [4:0]  id_ex_dst_q;
  logic [31:0] id_ex_npc_q, id_ex_a_q, id_ex_b_q, id_ex_imm_q;
  logic [5:0]  ex_mem_op_q;
  logic [4:0]  ex_mem_dst_q;
  logic [31:0] ex_mem_alu_q, ex_mem_b_q;
  logic [5:0]  mem_wb_op_q;
  logic [4:0]  mem_wb_dst_q;
  logic [31:0] mem_wb_res_q;

  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd, id_dst;
  logic [31:0] id_imm, id_a, id_b;
  instr_type_e id_type, ex_type;
  logic [31:0] alu_b, alu_y, ex_target, mem_result;
  logic        ex_taken, halt_pend;

  // Decode and operand fetch
  always_comb begin
    id_op   = if_id_ir_q[31:26];
    id_rs   = if_id_ir_q[25:21];
    id_rt   = if_id_ir_q[20:16];
    id_rd   = if_id_ir_q[15:11];
    id_imm  = {{16{if_id_ir_q[15]}}, if_id_ir_q[15:0]};
    id_type = decode_type(id_op);
    case (id_type)
      RR_ALU:       id_dst = id_rd;
      RM_ALU, LOAD: id_dst = id_rt;
      default:      id_dst = 5'd0;
    endcase
    mem_result = (decode_type(ex_mem_op_q) == LOAD) ? Mem[ex_mem_alu_q[9:0]] : ex_mem_alu_q;
    id_a = fwd_operand(id_rs, ex_mem_dst_q, mem_result, mem_wb_dst_q, mem_wb_res_q, Reg[id_rs]);
    id_b = fwd_operand(id_rt, ex_mem_dst_q, mem_result, mem_wb_dst_q, mem_wb_res_q, Reg[id_rt]);
  end

  // Execute: operand select, branch resolution and halt detection
  always_comb begin
    ex_type   = decode_type(id_ex_op_q);
    alu_b     = (ex_type == RR_ALU) ? id_ex_b_q : id_ex_imm_q;
    ex_taken  = (ex_type == BRANCH) && ((id_ex_op_q == OP_BEQZ) == (id_ex_a_q == 32'd0));
    ex_target = id_ex_npc_q + id_ex_imm_q;
    halt_pend = (id_op == OP_HLT) || (id_ex_op_q == OP_HLT) ||
                (ex_mem_op_q == OP_HLT) || (mem_wb_op_q == OP_HLT);
  end

  mips32_alu u_alu (
    .op_i (id_ex_op_q),
    .a_i  (id_ex_a_q),
    .b_i  (alu_b),
    .y_o  (alu_y)
  );

  // Pipeline registers; everything freezes once HALTED is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC <= 32'd0;  HALTED <= 1'b0;  TAKEN_BRANCH <= 1'b0;
      if_id_ir_q  <= NOP_INSTR; if_id_npc_q <= 32'd0;
      id_ex_op_q  <= 6'd0; id_ex_dst_q <= 5'd0; id_ex_npc_q <= 32'd0;
      id_ex_a_q   <= 32'd0; id_ex_b_q <= 32'd0; id_ex_imm_q <= 32'd0;
      ex_mem_op_q <= 6'd0; ex_mem_dst_q <= 5'd0; ex_mem_alu_q <= 32'd0; ex_mem_b_q <= 32'd0;
      mem_wb_op_q <= 6'd0; mem_wb_dst_q <= 5'd0; mem_wb_res_q <= 32'd0;
    end else if (!HALTED) begin
      TAKEN_BRANCH <= ex_taken;
      HALTED       <= (mem_wb_op_q == OP_HLT);
      if (ex_taken) begin
        PC          <= ex_target;
        if_id_ir_q  <= NOP_INSTR;
        if_id_npc_q <= 32'd0;
      end else if (halt_pend) begin
        if_id_ir_q  <= NOP_INSTR;
        if_id_npc_q <= 32'd0;
      end else begin
        if_id_ir_q  <= Mem[PC[9:0]];
        if_id_npc_q <= PC + 32'd1;
        PC          <= PC + 32'd1;
      end
      if (ex_taken) begin
        id_ex_op_q <= 6'd0; id_ex_dst_q <= 5'd0; id_ex_npc_q <= 32'd0;
        id_ex_a_q  <= 32'd0; id_ex_b_q <= 32'd0; id_ex_imm_q <= 32'd0;
      end else begin
        id_ex_op_q <= id_op; id_ex_dst_q <= id_dst; id_ex_npc_q <= if_id_npc_q;
        id_ex_a_q  <= id_a;  id_ex_b_q   <= id_b;   id_ex_imm_q <= id_imm;
      end
      ex_mem_op_q  <= id_ex_op_q;
      ex_mem_dst_q <= id_ex_dst_q;
      ex_mem_alu_q <= alu_y;
      ex_mem_b_q   <= id_ex_b_q;
      mem_wb_op_q  <= ex_mem_op_q;
      mem_wb_dst_q <= ex_mem_dst_q;
      mem_wb_res_q <= mem_result;
    end
  end

  // Architectural arrays carry no reset; the bench preloads them
  always_ff @(posedge clk) begin
    if (rst_n && !HALTED && decode_type(ex_mem_op_q) == STORE) begin
      Mem[ex_mem_alu_q[9:0]] <= ex_mem_b_q;
    end
    if (rst_n && !HALTED && mem_wb_dst_q != 5'd0) begin
      Reg[mem_wb_dst_q] <= mem_wb_res_q;
    end
  end

endmodule

// File: tb/tb_pipe_mips32.sv
// Directed self-checking bench for pipe_mips32: programs are preloaded hierarchically,
// results read back from Mem/Reg/PC/HALTED/TAKEN_BRANCH.
module tb_pipe_mips32;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010, OR_ = 6'b000011;
  localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001;
  localparam logic [5:0] ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101, HLT = 6'b111111;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   taken_cnt;
  logic halted_ok;
  logic [31:0] pc_snap;

  always #5 clk = ~clk;

  pipe_mips32 dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  function automatic logic [31:0] rt_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] im_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
    for (int k = 0; k < 32; k++) dut.Reg[k] = 32'(k);
  endtask

  task automatic load_loop_prog();
    dut.Mem[0] = im_i(ADDI, 5'd0, 5'd1, 16'd5);
    dut.Mem[1] = im_i(ADDI, 5'd0, 5'd2, 16'd0);
    dut.Mem[2] = rt_i(OR_, 5'd7, 5'd7, 5'd20);
    dut.Mem[3] = im_i(ADDI, 5'd2, 5'd2, 16'd1);
    dut.Mem[4] = im_i(SUBI, 5'd1, 5'd1, 16'd1);
    dut.Mem[5] = rt_i(OR_, 5'd7, 5'd7, 5'd20);
    dut.Mem[6] = im_i(BNEQZ, 5'd1, 5'd0, 16'hfffc);
    dut.Mem[7] = {HLT, 26'd0};
    dut.Mem[8] = im_i(ADDI, 5'd0, 5'd22, 16'd99);
  endtask

  task automatic run_to_halt(input int max_cycles);
    taken_cnt = 0;
    halted_ok = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (dut.TAKEN_BRANCH) taken_cnt++;
      if (dut.HALTED) begin
        halted_ok = 1'b1;
        break;
      end
    end
    check("halt_reached", {31'd0, halted_ok}, 32'd1);
  endtask

  initial begin
    // Reset is checked before any clock edge, so it must act asynchronously
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_pc", dut.PC, 32'd0);
    check("rst_halted", {31'd0, dut.HALTED}, 32'd0);
    check("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

    // Load / add / store program
    preload();
    dut.Mem[0] = 32'h28010078; dut.Mem[1] = 32'h0ce77800;
    dut.Mem[2] = 32'h20220000; dut.Mem[3] = 32'h0ce77800;
    dut.Mem[4] = 32'h2842002d; dut.Mem[5] = 32'h0ce77800;
    dut.Mem[6] = 32'h24220001; dut.Mem[7] = 32'hfc000000;
    dut.Mem[120] = 32'd85;
    @(negedge clk);
    rst_n = 1'b1;
    run_to_halt(200);
    check("ls_mem120", dut.Mem[120], 32'd85);
    check("ls_mem121", dut.Mem[121], 32'd130);
    check("ls_halted", {31'd0, dut.HALTED}, 32'd1);
    check("ls_r1", dut.Reg[1], 32'd120);
    check("ls_r2", dut.Reg[2], 32'd130);
    check("ls_r15", dut.Reg[15], 32'd7);
    check("ls_pc", dut.PC, 32'd8);

    // R-type, immediates, register 0 and MUL
    rst_n = 1'b0;
    preload();
    dut.Mem[0]  = im_i(ADDI, 5'd0, 5'd1, 16'd10);
    dut.Mem[1]  = im_i(ADDI, 5'd0, 5'd2, 16'd20);
    dut.Mem[2]  = rt_i(OR_, 5'd7, 5'd7, 5'd20);
    dut.Mem[3]  = rt_i(ADD, 5'd1, 5'd2, 5'd3);
    dut.Mem[4]  = rt_i(SUB, 5'd2, 5'd1, 5'd4);
    dut.Mem[5]  = rt_i(SLT, 5'd1, 5'd2, 5'd5);
    dut.Mem[6]  = im_i(ADDI, 5'd0, 5'd0, 16'd5);
    dut.Mem[7]  = im_i(ADDI, 5'd0, 5'd10, 16'hfffd);
    dut.Mem[8]  = rt_i(AND_, 5'd1, 5'd2, 5'd12);
    dut.Mem[9]  = rt_i(SLT, 5'd10, 5'd1, 5'd11);
    dut.Mem[10] = rt_i(SLT, 5'd1, 5'd10, 5'd13);
    dut.Mem[11] = rt_i(OR_, 5'd1, 5'd2, 5'd14);
    dut.Mem[12] = rt_i(MUL, 5'd7, 5'd6, 5'd6);
    dut.Mem[13] = im_i(SUBI, 5'd1, 5'd16, 16'd11);
    dut.Mem[14] = im_i(SLTI, 5'd10, 5'd19, 16'hfffe);
    dut.Mem[15] = {HLT, 26'd0};
    @(negedge clk);
    rst_n = 1'b1;
    run_to_halt(200);
    check("rr_add", dut.Reg[3], 32'd30);
    check("rr_sub", dut.Reg[4], 32'd10);
    check("rr_slt", dut.Reg[5], 32'd1);
    check("r0_keep", dut.Reg[0], 32'd0);
    check("addi_neg", dut.Reg[10], 32'hfffffffd);
    check("rr_and", dut.Reg[12], 32'd0);
    check("slt_signed_t", dut.Reg[11], 32'd1);
    check("slt_signed_f", dut.Reg[13], 32'd0);
    check("rr_or", dut.Reg[14], 32'd30);
    check("subi_wrap", dut.Reg[16], 32'hffffffff);
    check("slti_neg", dut.Reg[19], 32'd1);
`ifdef PIPE_MIPS32_MUL_EN
    check("mul", dut.Reg[6], 32'd42);
`else
    check("mul_off", dut.Reg[6], 32'd6);
`endif

    // Branch loop: squashed HLT/ADDI must have no effect
    rst_n = 1'b0;
    preload();
    load_loop_prog();
    @(negedge clk);
    rst_n = 1'b1;
    run_to_halt(300);
    check("br_count", dut.Reg[2], 32'd5);
    check("br_r1", dut.Reg[1], 32'd0);
    check("br_squash", dut.Reg[22], 32'd22);
    check("br_taken", 32'(taken_cnt), 32'd4);
    check("br_pc", dut.PC, 32'd8);

    // HLT stops fetch and freezes state
    rst_n = 1'b0;
    preload();
    dut.Mem[0] = im_i(ADDI, 5'd0, 5'd1, 16'd3);
    dut.Mem[1] = {HLT, 26'd0};
    dut.Mem[2] = im_i(ADDI, 5'd0, 5'd9, 16'd7);
    @(negedge clk);
    rst_n = 1'b1;
    run_to_halt(100);
    check("hlt_r1", dut.Reg[1], 32'd3);
    check("hlt_r9", dut.Reg[9], 32'd9);
    check("hlt_pc", dut.PC, 32'd2);
    pc_snap = dut.PC;
    repeat (10) @(negedge clk);
    check("hlt_pc_frozen", dut.PC, pc_snap);
    check("hlt_still", {31'd0, dut.HALTED}, 32'd1);
    check("hlt_r9_late", dut.Reg[9], 32'd9);

    // Reset mid-program, then a clean rerun
    rst_n = 1'b0;
    preload();
    load_loop_prog();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pc", dut.PC, 32'd0);
    check("mid_rst_halted", {31'd0, dut.HALTED}, 32'd0);
    check("mid_rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_to_halt(300);
    check("rerun_count", dut.Reg[2], 32'd5);
    check("rerun_r1", dut.Reg[1], 32'd0);
    check("rerun_taken", 32'(taken_cnt), 32'd4);
    check("rerun_squash", dut.Reg[22], 32'd22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
